// File: rtl/uart_rx_if.sv
// uart_rx_if: consumer-side bundle of the UART receiver.
//   read        consumer acknowledge, pops the held byte
//   read_data   last accepted byte, LSB = first received bit
//   read_valid  read_data holds an unread byte
//   frame_err   1-cycle pulse, stop bit sampled low
//   parity_err  1-cycle pulse, even-parity mismatch
//   overrun     1-cycle pulse, completed byte dropped (previous byte unread)
// Modports: slave = receiver side, master = consumer (bus glue) side.
interface uart_rx_if #(
    parameter int DataBitsSize = 8
);
    logic                    read;
    logic [DataBitsSize-1:0] read_data;
    logic                    read_valid;
    logic                    frame_err;
    logic                    parity_err;
    logic                    overrun;

    modport slave (
        input  read,
        output read_data, read_valid, frame_err, parity_err, overrun
    );

    modport master (
        output read,
        input  read_data, read_valid, frame_err, parity_err, overrun
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, LSB-first frames, optional even parity.
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   rx_sig  asynchronous serial input, idle high
//   bus     uart_rx_if.slave: read / read_data / read_valid handshake plus
//           frame_err, parity_err, overrun single-cycle pulses
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for a low level on rx_s
// START     | timing to mid start bit, re-checking it is still low
// DATA      | sampling data bits at mid-bit, shifting in LSB first
// PARITY    | sampling the even-parity bit
// STOP      | sampling the stop bit, arming delivery for the next cycle
// WAIT_IDLE | framing error seen, waiting for the line to return high
module uart_rx #(
    parameter int BaudRate     = 115200,
    parameter int ParityBit    = 0,
    parameter int DataBitsSize = 8,
    parameter int ClockFreqHz  = 10000000
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     rx_sig,
    uart_rx_if.slave bus
);

    localparam int SClkPeriod = ClockFreqHz / BaudRate;
    localparam int HalfPeriod = SClkPeriod / 2;
    localparam int BcW        = $clog2(DataBitsSize + 1);

    // Counters run from 0 and wrap on the terminal count, so a bit spans
    // exactly SClkPeriod cycles and the start check lands HalfPeriod cycles
    // after the low level is first seen.
    localparam logic [31:0]    HalfTc = 32'(HalfPeriod - 1);
    localparam logic [31:0]    BitTc  = 32'(SClkPeriod - 1);
    localparam logic [BcW-1:0] BitsM1 = BcW'(DataBitsSize - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    state_t                  state, state_nxt;
    logic                    rx_meta, rx_s;
    logic [31:0]             clk_cnt, clk_cnt_nxt;
    logic [BcW-1:0]          bit_cnt, bit_cnt_nxt;
    logic [DataBitsSize-1:0] shift_reg, shift_nxt;
    logic                    parity_bad, parity_bad_nxt;
    logic                    done, done_nxt;
    logic                    stop_ok, stop_ok_nxt;

    logic [DataBitsSize-1:0] read_data_q;
    logic                    read_valid_q;
    logic                    frame_err_q, parity_err_q, overrun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_sig;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bad <= 1'b0;
            done       <= 1'b0;
            stop_ok    <= 1'b0;
        end else begin
            state      <= state_nxt;
            clk_cnt    <= clk_cnt_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shift_reg  <= shift_nxt;
            parity_bad <= parity_bad_nxt;
            done       <= done_nxt;
            stop_ok    <= stop_ok_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        clk_cnt_nxt    = '0;
        bit_cnt_nxt    = bit_cnt;
        shift_nxt      = shift_reg;
        parity_bad_nxt = parity_bad;
        done_nxt       = 1'b0;
        stop_ok_nxt    = stop_ok;
        case (state)
            IDLE: begin
                if (!rx_s) state_nxt = START;
            end
            START: begin
                parity_bad_nxt = 1'b0;
                if (clk_cnt == HalfTc) begin
                    bit_cnt_nxt = '0;
                    // A start bit that is high again at mid-bit was a glitch.
                    state_nxt   = rx_s ? IDLE : DATA;
                end else begin
                    clk_cnt_nxt = clk_cnt + 32'd1;
                end
            end
            DATA: begin
                if (clk_cnt == BitTc) begin
                    shift_nxt   = {rx_s, shift_reg[DataBitsSize-1:1]};
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    if (bit_cnt == BitsM1)
                        state_nxt = (ParityBit != 0) ? PARITY : STOP;
                end else begin
                    clk_cnt_nxt = clk_cnt + 32'd1;
                end
            end
            PARITY: begin
                if (clk_cnt == BitTc) begin
                    parity_bad_nxt = ((^shift_reg) != rx_s);
                    state_nxt      = STOP;
                end else begin
                    clk_cnt_nxt = clk_cnt + 32'd1;
                end
            end
            STOP: begin
                if (clk_cnt == BitTc) begin
                    done_nxt    = 1'b1;
                    stop_ok_nxt = rx_s;
                    // A low stop bit may be a break; hold off until the line
                    // goes high so a long low does not produce more frames.
                    state_nxt   = rx_s ? IDLE : WAIT_IDLE;
                end else begin
                    clk_cnt_nxt = clk_cnt + 32'd1;
                end
            end
            WAIT_IDLE: begin
                if (rx_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Delivery runs one cycle after the stop sample. shift_reg and parity_bad
    // are still intact then because IDLE/WAIT_IDLE do not touch them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
            if (bus.read && read_valid_q) read_valid_q <= 1'b0;
            if (done) begin
                if (!stop_ok) begin
                    frame_err_q <= 1'b1;
                end else if (parity_bad) begin
                    parity_err_q <= 1'b1;
                end else if (!read_valid_q || bus.read) begin
                    read_data_q  <= shift_reg;
                    read_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end
        end
    end

    assign bus.read_data  = read_data_q;
    assign bus.read_valid = read_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.parity_err = parity_err_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx.
// dut0 runs without parity, dut1 with even parity; both at default baud/clock.
// The reference model works per frame: it knows the bits it put on the line
// and predicts the held byte, the error pulse counts and the latency from the
// start edge on the pin to read_valid.
module tb_uart_rx;
    localparam int ClockFreqHz = 10000000;
    localparam int BaudRate    = 115200;
    localparam int DataBits    = 8;
    localparam int SClk        = ClockFreqHz / BaudRate;
    localparam int Half        = SClk / 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx0   = 1'b1;
    logic rx1   = 1'b1;

    always #5 clk = ~clk;

    uart_rx_if #(.DataBitsSize(DataBits)) bus0 ();
    uart_rx_if #(.DataBitsSize(DataBits)) bus1 ();

    uart_rx #(.BaudRate(BaudRate), .ParityBit(0), .DataBitsSize(DataBits),
              .ClockFreqHz(ClockFreqHz))
        dut0 (.clk(clk), .rst_n(rst_n), .rx_sig(rx0), .bus(bus0));

    uart_rx #(.BaudRate(BaudRate), .ParityBit(1), .DataBitsSize(DataBits),
              .ClockFreqHz(ClockFreqHz))
        dut1 (.clk(clk), .rst_n(rst_n), .rx_sig(rx1), .bus(bus1));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters and read_valid rise times, observed away from the edge.
    int   rise   [2] = '{0, 0};
    int   fe_cnt [2] = '{0, 0};
    int   pe_cnt [2] = '{0, 0};
    int   ov_cnt [2] = '{0, 0};
    logic rv_q   [2] = '{1'b0, 1'b0};

    always @(negedge clk) begin
        if (bus0.read_valid && !rv_q[0]) rise[0] = cyc;
        if (bus1.read_valid && !rv_q[1]) rise[1] = cyc;
        rv_q[0] = bus0.read_valid;
        rv_q[1] = bus1.read_valid;
        fe_cnt[0] += int'(bus0.frame_err);
        pe_cnt[0] += int'(bus0.parity_err);
        ov_cnt[0] += int'(bus0.overrun);
        fe_cnt[1] += int'(bus1.frame_err);
        pe_cnt[1] += int'(bus1.parity_err);
        ov_cnt[1] += int'(bus1.overrun);
    end

    // Reference model state.
    bit         mv     [2] = '{1'b0, 1'b0};
    logic [7:0] md     [2] = '{8'h00, 8'h00};
    int         fe_exp [2] = '{0, 0};
    int         pe_exp [2] = '{0, 0};
    int         ov_exp [2] = '{0, 0};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic get_rv(input int sel);
        return (sel == 1) ? bus1.read_valid : bus0.read_valid;
    endfunction

    function automatic logic [7:0] get_rd(input int sel);
        return (sel == 1) ? bus1.read_data : bus0.read_data;
    endfunction

    task automatic set_line(input int sel, input logic v);
        if (sel == 1) rx1 = v;
        else          rx0 = v;
    endtask

    task automatic set_read(input int sel, input logic v);
        if (sel == 1) bus1.read = v;
        else          bus0.read = v;
    endtask

    task automatic check_state(input int sel, input string tag);
        check_eq({tag, "_valid"}, 32'(get_rv(sel)), 32'(mv[sel]));
        if (mv[sel]) check_eq({tag, "_data"}, 32'(get_rd(sel)), 32'(md[sel]));
        check_eq({tag, "_frame_err"}, fe_cnt[sel], fe_exp[sel]);
        check_eq({tag, "_parity_err"}, pe_cnt[sel], pe_exp[sel]);
        check_eq({tag, "_overrun"}, ov_cnt[sel], ov_exp[sel]);
    endtask

    task automatic pop(input int sel);
        set_read(sel, 1'b1);
        @(negedge clk);
        set_read(sel, 1'b0);
        mv[sel] = 1'b0;
        check_eq("pop_valid", 32'(get_rv(sel)), 32'd0);
    endtask

    // One frame on the pin, each bit held SClk cycles. rd_stop pulses read
    // in the cycle whose closing edge takes the stop sample; hold_low keeps
    // the line low afterwards (break).
    task automatic run_frame(input int sel, input logic [7:0] data, input bit bad_par,
                             input bit stop_bit, input bit rd_stop, input int hold_low,
                             input string tag);
        logic [15:0] frame;
        int nb, c0, exp_lat, rk;
        bit load;
        nb = 10 + sel;
        frame = '1;
        frame[0] = 1'b0;
        frame[8:1] = data;
        if (sel == 1) frame[9] = (^data) ^ bad_par;
        frame[nb-1] = stop_bit;
        // 2 sync flops + idle detect + half bit + remaining bits + delivery
        exp_lat = 2 + 1 + Half + (nb - 1) * SClk + 1;
        rk = exp_lat - 2;
        c0 = cyc;
        for (int k = 0; k < nb * SClk; k++) begin
            set_line(sel, frame[k / SClk]);
            set_read(sel, rd_stop && (k == rk));
            @(negedge clk);
        end
        set_read(sel, 1'b0);
        if (hold_low > 0) begin
            set_line(sel, 1'b0);
            repeat (hold_low) @(negedge clk);
        end
        set_line(sel, 1'b1);
        repeat (30) @(negedge clk);

        load = 1'b0;
        if (rd_stop) mv[sel] = 1'b0;
        if (!stop_bit) fe_exp[sel]++;
        else if (sel == 1 && bad_par) pe_exp[sel]++;
        else if (!mv[sel]) begin
            mv[sel] = 1'b1;
            md[sel] = data;
            load = 1'b1;
        end else ov_exp[sel]++;
        if (load) check_eq({tag, "_latency"}, rise[sel] - c0, exp_lat);
        check_state(sel, tag);
    endtask

    initial begin
        logic [7:0] d;
        bit st, rs, bp;
        bus0.read = 1'b0;
        bus1.read = 1'b0;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("rst_valid0", 32'(bus0.read_valid), 32'd0);
        check_eq("rst_data0", 32'(bus0.read_data), 32'd0);
        check_eq("rst_pulses0", {29'd0, bus0.frame_err, bus0.parity_err, bus0.overrun}, 32'd0);
        check_eq("rst_valid1", 32'(bus1.read_valid), 32'd0);
        rst_n = 1'b1;

        repeat (1000) @(negedge clk);
        check_state(0, "idle0");
        check_state(1, "idle1");

        run_frame(0, 8'hA5, 1'b0, 1'b1, 1'b0, 0, "a5");
        pop(0);

        set_line(0, 1'b0);
        repeat (20) @(negedge clk);
        set_line(0, 1'b1);
        repeat (200) @(negedge clk);
        check_state(0, "glitch");
        run_frame(0, 8'h3C, 1'b0, 1'b1, 1'b0, 0, "3c");
        pop(0);

        run_frame(0, 8'h99, 1'b0, 1'b0, 1'b0, 500, "break");
        run_frame(0, 8'h55, 1'b0, 1'b1, 1'b0, 0, "55");
        pop(0);

        run_frame(0, 8'h11, 1'b0, 1'b1, 1'b0, 0, "ovr_11");
        run_frame(0, 8'h22, 1'b0, 1'b1, 1'b0, 0, "ovr_22");
        run_frame(0, 8'h22, 1'b0, 1'b1, 1'b1, 0, "rdstop_22");
        pop(0);

        for (int i = 0; i < 25; i++) begin
            if (mv[0] && $urandom_range(0, 1) == 1) pop(0);
            d  = 8'($urandom);
            st = ($urandom_range(0, 7) != 0);
            rs = ($urandom_range(0, 3) == 0);
            run_frame(0, d, 1'b0, st, rs, st ? 0 : int'($urandom_range(0, 200)), "rnd0");
        end

        run_frame(1, 8'h07, 1'b0, 1'b1, 1'b0, 0, "par_ok");
        pop(1);
        run_frame(1, 8'h07, 1'b1, 1'b1, 1'b0, 0, "par_bad");
        for (int i = 0; i < 12; i++) begin
            if (mv[1] && $urandom_range(0, 1) == 1) pop(1);
            d  = 8'($urandom);
            bp = ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 3) == 0);
            run_frame(1, d, bp, 1'b1, rs, 0, "rnd1");
        end

        if (mv[1]) pop(1);
        run_frame(1, 8'hC3, 1'b0, 1'b1, 1'b0, 0, "pre_rst");
        set_line(1, 1'b0);
        repeat (300) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("midrst_valid1", 32'(bus1.read_valid), 32'd0);
        check_eq("midrst_data1", 32'(bus1.read_data), 32'd0);
        check_eq("midrst_pulses1", {29'd0, bus1.frame_err, bus1.parity_err, bus1.overrun}, 32'd0);
        check_eq("midrst_valid0", 32'(bus0.read_valid), 32'd0);
        mv[0] = 1'b0;
        mv[1] = 1'b0;
        set_line(1, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (1200) @(negedge clk);
        check_state(0, "post_rst0");
        check_state(1, "post_rst1");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
